// File: rtl/u409_cia_cycle.sv
// CIA bus-cycle sequencer: free-running E clock divider plus the
// FSM that aligns CPU cycles to E and terminates them with one ACK.
module u409_cia_cycle #(
  parameter int E_DIV   = 10,
  parameter int E_RISE  = 6,
  parameter int CS_LEAD = 2
) (
  input  logic clk7_i,
  input  logic reset_i,
  input  logic cyc_req_i,
  input  logic cia_space_i,
  input  logic rnw_i,
  output logic e_o,
  output logic cia_enable_o,
  output logic cia_latch_o,
  output logic cia_ack_o
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ACTIVE,
    TERM,
    HOLD
  } state_e;

  localparam logic [3:0] LAST = 4'(E_DIV - 1);
  localparam logic [3:0] RISE = 4'(E_RISE);
  localparam logic [3:0] GO   = 4'(E_RISE - CS_LEAD - 1);

  logic [3:0] ecnt_q, ecnt_d;
  state_e     state_q, state_d;
  logic       e_q, en_q, latch_q, ack_q;
  logic       e_d, en_d, latch_d, ack_d;

  assign ecnt_d = (ecnt_q == LAST) ? 4'd0 : ecnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cyc_req_i && cia_space_i) state_d = SYNC;
      end
      SYNC: begin
        // abort wins over the ECNT match
        if (!cyc_req_i)        state_d = IDLE;
        else if (ecnt_q == GO) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (ecnt_q == LAST) state_d = TERM;
      end
      TERM: state_d = HOLD;
      HOLD: begin
        if (!cyc_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs registered from next-state so they align with ECNT
  always_comb begin
    e_d     = (ecnt_d >= RISE);
    en_d    = (state_d == ACTIVE);
    latch_d = en_d && (ecnt_d == LAST) && rnw_i;
    ack_d   = (state_d == TERM);
  end

  always_ff @(posedge clk7_i or posedge reset_i) begin
    if (reset_i) begin
      ecnt_q  <= 4'd0;
      state_q <= IDLE;
      e_q     <= 1'b0;
      en_q    <= 1'b0;
      latch_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ecnt_q  <= ecnt_d;
      state_q <= state_d;
      e_q     <= e_d;
      en_q    <= en_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
    end
  end

  assign e_o          = e_q;
  assign cia_enable_o = en_q;
  assign cia_latch_o  = latch_q;
  assign cia_ack_o    = ack_q;

endmodule

// File: tb/tb_u409_cia_cycle.sv
// Bench for u409_cia_cycle: vector table of request scenarios with
// per-cycle expectations queued at drive time and popped each cycle.
module tb_u409_cia_cycle;

  logic clk7 = 1'b0;
  logic reset, cyc_req, cia_space, rnw;
  logic e, cia_enable, cia_latch, cia_ack;

  u409_cia_cycle dut (
    .clk7_i      (clk7),
    .reset_i     (reset),
    .cyc_req_i   (cyc_req),
    .cia_space_i (cia_space),
    .rnw_i       (rnw),
    .e_o         (e),
    .cia_enable_o(cia_enable),
    .cia_latch_o (cia_latch),
    .cia_ack_o   (cia_ack)
  );

  always #5 clk7 = ~clk7;

  typedef struct {
    logic en;
    logic latch;
    logic ack;
  } exp_t;

  typedef struct {
    logic rnw;
    logic space;
    int   s;
    int   hold;
    int   drop;
    int   en_first;
    int   ack;
  } vec_t;

  exp_t q[$];
  vec_t tv[9];
  int   checks = 0;
  int   errors = 0;
  int   ecnt_m = 0;

  task automatic chk(input string nm, input logic act,
                     input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s ecnt=%0d got %b want %b",
               nm, ecnt_m, act, req);
    end
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk7);
    ecnt_m = (ecnt_m == 9) ? 0 : ecnt_m + 1;
    @(negedge clk7);
    x = '{1'b0, 1'b0, 1'b0};
    if (q.size() > 0) x = q.pop_front();
    chk("e", e, ecnt_m >= 6);
    chk("enable", cia_enable, x.en);
    chk("latch", cia_latch, x.latch);
    chk("ack", cia_ack, x.ack);
  endtask

  task automatic push_win(input vec_t v, input int w);
    exp_t x;
    for (int j = 1; j <= w; j++) begin
      x.en = (v.en_first != 0) && (j >= v.en_first)
             && (j <= v.en_first + 5);
      x.latch = x.en && (j == v.en_first + 5) && v.rnw;
      x.ack = (v.ack != 0) && (j == v.ack);
      q.push_back(x);
    end
  endtask

  initial begin
    int w;
    vec_t v;
    //         rnw  spc  s  hold drop en  ack
    tv[0] = '{1'b1, 1'b1, 1, 0,  0,  3,  9};
    tv[1] = '{1'b0, 1'b1, 3, 0,  0,  11, 17};
    tv[2] = '{1'b1, 1'b1, 1, 30, 0,  3,  9};
    tv[3] = '{1'b1, 1'b1, 5, 0,  3,  0,  0};
    tv[4] = '{1'b1, 1'b1, 1, 0,  6,  3,  9};
    tv[5] = '{1'b1, 1'b0, 2, 0,  2,  0,  0};
    tv[6] = '{1'b0, 1'b1, 9, 0,  0,  5,  11};
    tv[7] = '{1'b1, 1'b1, 4, 0,  0,  10, 16};
    tv[8] = '{1'b1, 1'b1, 0, 0,  0,  4,  10};

    reset = 1'b1;
    cyc_req = 1'b0;
    cia_space = 1'b0;
    rnw = 1'b1;
    repeat (3) @(posedge clk7);
    @(negedge clk7);
    chk("rst_e", e, 1'b0);
    chk("rst_enable", cia_enable, 1'b0);
    chk("rst_latch", cia_latch, 1'b0);
    chk("rst_ack", cia_ack, 1'b0);
    reset = 1'b0;
    ecnt_m = 0;
    repeat (20) tick();

    for (int i = 0; i < 9; i++) begin
      v = tv[i];
      while (ecnt_m != v.s) tick();
      cyc_req = 1'b1;
      cia_space = v.space;
      rnw = v.rnw;
      w = (v.ack != 0) ? v.ack + v.hold + 2 : 15;
      push_win(v, w);
      for (int j = 1; j <= w; j++) begin
        tick();
        cia_space = 1'b0;
        if (v.drop != 0 && j + 1 == v.drop) cyc_req = 1'b0;
        if (v.ack != 0 && j == v.ack + v.hold) cyc_req = 1'b0;
      end
      cyc_req = 1'b0;
      repeat (3) tick();
    end

    // reset mid-ACTIVE at ECNT 7
    v = '{1'b1, 1'b1, 1, 0, 0, 3, 0};
    while (ecnt_m != 1) tick();
    cyc_req = 1'b1;
    cia_space = 1'b1;
    rnw = 1'b1;
    push_win(v, 6);
    for (int j = 1; j <= 6; j++) begin
      tick();
      cia_space = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_e", e, 1'b0);
    chk("arst_enable", cia_enable, 1'b0);
    chk("arst_ack", cia_ack, 1'b0);
    q.delete();
    cyc_req = 1'b0;
    repeat (2) @(posedge clk7);
    @(negedge clk7);
    reset = 1'b0;
    ecnt_m = 0;
    repeat (25) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/u409_cia_cycle.md
U409_CIA_CYCLE -- requirements
Module: u409_cia_cycle

Interface
REQ-001 Parameter E_DIV, default 10, CLK7 cycles per E period; legal range 8..15.
REQ-002 Parameter E_RISE, default 6, ECNT value at which E is high; E high for ECNT E_RISE..E_DIV-1.
REQ-003 Parameter CS_LEAD, default 2, CLK7 cycles CIA_ENABLE leads E rise; legal range 1..E_RISE-1.
REQ-004 CLK7  input  1  7.09 MHz system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 CYC_REQ  input  1  CPU bus cycle in progress, synchronous to CLK7, held high until CIA_ACK seen.
REQ-007 CIA_SPACE  input  1  from address decode; A[31:16] = $00BF.
REQ-008 RnW  input  1  1 = read, 0 = write; stable while CYC_REQ high.
REQ-009 E  output  1  registered 6800-style E clock to both CIAs.
REQ-010 CIA_ENABLE  output  1  registered; qualifies nCIACS0/nCIACS1 in address decode.
REQ-011 CIA_LATCH  output  1  registered one-cycle read-data capture strobe.
REQ-012 CIA_ACK  output  1  registered one-cycle cycle-termination pulse to the CPU bus controller.

Function
REQ-013 ECNT (4 bits) SHALL increment every CLK7 edge, wrapping E_DIV-1 -> 0, free-running regardless of state.
REQ-014 E SHALL be 1 exactly while ECNT is in E_RISE..E_DIV-1 (defaults: 4 high, 6 low), with E registered alongside ECNT and no extra lag.
REQ-015 FSM states SHALL be IDLE, SYNC, ACTIVE, TERM and HOLD.
REQ-016 IDLE -> SYNC when CYC_REQ && CIA_SPACE are sampled high; any ECNT.
REQ-017 SYNC -> ACTIVE on the edge where sampled ECNT = E_RISE-CS_LEAD-1; entry at ECNT = E_RISE-1-CS_LEAD+1 = ECNT 4 for the defaults.
REQ-018 SYNC -> IDLE if CYC_REQ is sampled low (abort); no CIA_ENABLE, no ACK.
REQ-019 CIA_ENABLE SHALL be 1 exactly while state = ACTIVE (defaults: ECNT 4..9, 6 cycles).
REQ-020 ACTIVE -> TERM on the edge where sampled ECNT = E_DIV-1; the E falling edge and the CIA_ENABLE falling edge coincide.
REQ-021 CIA_LATCH SHALL be 1 for the single cycle with state = ACTIVE, ECNT = E_DIV-1 and RnW = 1; 0 for writes.
REQ-022 CIA_ACK SHALL be 1 exactly while state = TERM (one cycle); TERM -> HOLD unconditionally.
REQ-023 HOLD -> IDLE when CYC_REQ is sampled low; remain in HOLD while it is high, so one request yields one ACK.
REQ-024 CYC_REQ deasserting during ACTIVE SHALL NOT shorten the cycle; ACTIVE, TERM and ACK complete, then HOLD exits on the next edge.
REQ-025 A request sampled in IDLE exactly at ECNT = E_RISE-CS_LEAD-1 enters SYNC and waits the full next E period; it SHALL NOT enter ACTIVE directly.
REQ-026 Worst-case latency CYC_REQ -> CIA_ACK SHALL be <= 2*E_DIV+1 CLK7 cycles; best case is CS_LEAD + (E_DIV-E_RISE) + 2.
REQ-027 CIA_SPACE SHALL be ignored outside IDLE.

Reset
REQ-028 While RESET = 1: ECNT = 0, state = IDLE, E = 0, CIA_ENABLE = 0, CIA_LATCH = 0, CIA_ACK = 0.
REQ-029 RESET asserted mid-cycle SHALL clear outputs immediately (asynchronously) with no ACK; after release ECNT restarts from 0.

Verification
REQ-030 Reset release, idle, defaults: E pattern 0,0,0,0,0,0,1,1,1,1 repeating from ECNT 0; CIA_ENABLE, ACK and LATCH stay 0.
REQ-031 Read with request sampled at ECNT 1: SYNC; CIA_ENABLE high ECNT 4..9; LATCH at ECNT 9; ACK at the following ECNT 0; total 10 cycles.
REQ-032 Write with request sampled at ECNT 3: no ACTIVE in the current period; ENABLE high at ECNT 4 of the next period; LATCH stays 0; ACK after 17 cycles.
REQ-033 Request held high for 30 cycles after ACK: exactly one ACK pulse; IDLE on the first edge after CYC_REQ falls.
REQ-034 CYC_REQ dropped in SYNC: no ENABLE, no ACK. CYC_REQ dropped at ECNT 6 in ACTIVE: ENABLE through ECNT 9, ACK at ECNT 0.
REQ-035 RESET pulsed at ECNT 7 in ACTIVE: ENABLE and E go 0 asynchronously; no ACK afterward; ECNT = 0 on the first edge after release.
